pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 99 +++++++++
 tb/tb_pc_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Fetch program-counter controller: sequential advance, jr/jump/branch redirects,
// and a single-entry redirect buffer that parks a target while instruction memory is busy.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_wait,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pend
);

  // state | meaning
  // RUN   | no redirect parked; pc advances or redirects when memory is ready
  // PEND  | a redirect target is parked in pend_target_q until if_wait drops
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        req;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] sel_target;
  logic [31:0] seq_pc;

  assign req        = jr | jump | (br_valid & br_taken);
  assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
  // pc already holds the delay-slot address, so the branch base needs no adjustment
  assign br_target  = pc_q + br_offset;
  assign jmp_target = {pc_q[31:28], instr_index, 2'b00};
  assign seq_pc     = pc_q + 32'd4;

  always_comb begin
    sel_target = br_target;
    if (jr) begin
      sel_target = jr_target;
    end else if (jump) begin
      sel_target = jmp_target;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (!if_wait) begin
            pc_d = req ? sel_target : seq_pc;
          end else if (req) begin
            pend_target_d = sel_target;
            state_d       = ST_PEND;
          end
        end
        ST_PEND: begin
          // first captured redirect wins; requests seen while parked are dropped
          if (!if_wait) begin
            pc_d    = pend_target_q;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = seq_pc;
  assign redirect_pend = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed scenarios then random traffic against a
// queue-based reference model of the fetch address and parked redirect.
module tb_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        if_wait = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic        jump = 1'b0;
  logic [25:0] instr_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pend;

  pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .if_wait      (if_wait),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .imm16        (imm16),
    .jump         (jump),
    .instr_index  (instr_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect_pend(redirect_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pend;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // reference model state: the fetch address plus at most one parked redirect
  logic [31:0] m_pc;
  logic [31:0] m_park[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk32({e.tag, " pc"}, pc, e.pc);
      chk32({e.tag, " pc_plus4"}, pc_plus4, e.pc4);
      chk32({e.tag, " redirect_pend"}, {31'd0, redirect_pend}, {31'd0, e.pend});
    end
  end

  // Caller is positioned just after a falling edge; returns just after the next one.
  task automatic step(input string tag, input logic st, input logic w,
                      input logic bv, input logic bt, input logic [15:0] imm,
                      input logic j, input logic [25:0] idx,
                      input logic r, input logic [31:0] rt);
    logic        want;
    logic [31:0] dest;
    logic signed [31:0] off;
    exp_t e;
    stall = st; if_wait = w; br_valid = bv; br_taken = bt; imm16 = imm;
    jump = j; instr_index = idx; jr = r; jr_target = rt;
    want = r | j | (bv & bt);
    off  = 32'(signed'(imm));
    if (r)      dest = rt;
    else if (j) dest = {m_pc[31:28], 28'(idx) * 28'd4};
    else        dest = m_pc + 32'(off * 4);
    if (!st) begin
      if (m_park.size() > 0) begin
        if (!w) m_pc = m_park.pop_front();
      end else if (!w) begin
        m_pc = want ? dest : m_pc + 32'd4;
      end else if (want) begin
        m_park.push_back(dest);
      end
    end
    @(posedge clk);
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.pend = (m_park.size() > 0); e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    step("goto", 0, 0, 0, 0, 16'h0, 0, 26'h0, 1, a);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    stall = 0; if_wait = 0; br_valid = 0; br_taken = 0; jump = 0; jr = 0;
    m_pc = RST_PC;
    m_park.delete();
    #1;
    chk32({tag, " async pc"}, pc, RST_PC);
    chk32({tag, " async pend"}, {31'd0, redirect_pend}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk32({tag, " held pc"}, pc, RST_PC);
    reset = 1'b0;
  endtask

  initial begin
    m_pc = RST_PC;
    @(negedge clk);
    #1;
    apply_reset("por");
    idle("free1");
    idle("free2");

    step("br_taken_back", 0, 0, 1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
    goto_pc(32'h0000_3008);
    step("br_not_taken", 0, 0, 1, 0, 16'hFFFE, 0, 26'h0, 0, 32'h0);

    goto_pc(32'h0000_3010);
    step("jump_over_br", 0, 0, 1, 1, 16'h0010, 1, 26'h0000C10, 0, 32'h0);
    goto_pc(32'h0000_3010);
    step("jr_over_all", 0, 0, 1, 1, 16'h0010, 1, 26'h0000C10, 1, 32'h0000_4000);

    goto_pc(32'h0000_3004);
    step("wait_capture", 0, 1, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0);
    step("wait_ignore_j", 0, 1, 0, 0, 16'h0, 1, 26'h0123456, 0, 32'h0);
    step("wait_release", 0, 0, 0, 0, 16'h0, 1, 26'h0123456, 0, 32'h0);

    goto_pc(32'h0000_3004);
    step("stall_over_wait", 1, 1, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0);
    step("stall_hold_rdy", 1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_8888);
    step("enter_pend", 0, 1, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0);
    step("pend_stall", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    apply_reset("reset_in_pend");
    idle("post_reset");

    goto_pc(32'hFFFF_FFFC);
    idle("wrap");

    for (int i = 0; i < 400; i++) begin
      logic st, w, bv, bt, j, r;
      st = ($urandom_range(7) == 0);
      w  = ($urandom_range(3) == 0);
      bv = ($urandom_range(2) == 0);
      bt = $urandom_range(1) == 1;
      j  = ($urandom_range(5) == 0);
      r  = ($urandom_range(6) == 0);
      step("rand", st, w, bv, bt, 16'($urandom), j, 26'($urandom), r, $urandom);
    end

    chk32("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
